// File: rtl/reg_file_2w2r.sv
// Parametrised register file with two write ports and two read ports.
// Optional hardwired-zero register 0, write-to-read bypass and registered reads.
module reg_file_2w2r #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [WIDTH-1:0]  d_in_0,
  input  logic              wr_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [WIDTH-1:0]  d_in_1,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b
);

  logic [1:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr [2];
  logic [WIDTH-1:0]  wr_data [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [1:0]        wr_ok;
  logic [1:0]        wr_in_range;
  logic [1:0]        rd_in_range;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rd_val [2];

  assign wr_en      = {wr_1, wr_0};
  assign wr_addr[0] = wr_addr_0;
  assign wr_addr[1] = wr_addr_1;
  assign wr_data[0] = d_in_0;
  assign wr_data[1] = d_in_1;
  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // A write is live only in range, outside reset, and not aimed at a hardwired zero.
  always_comb begin
    wr_in_range = '0;
    wr_ok       = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr[p] == ADDR_W'(i)) wr_in_range[p] = 1'b1;
      end
      wr_ok[p] = wr_en[p] && wr_in_range[p] && !reset &&
                 !((ZERO_REG != 0) && (wr_addr[p] == '0));
    end
  end

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no
  // latch is inferred; port 1 is applied after port 0 and therefore wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_ok[p] && (wr_addr[p] == ADDR_W'(i))) mem_d[i] = wr_data[p];
      end
    end
  end

  // NOTE: the storage must clear on reset, so it is built from resettable flops
  // rather than a RAM macro; sequential state is updated with non-blocking '<='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_in_range = '0;
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) begin
          rd_in_range[p] = 1'b1;
          rd_val[p]      = mem_q[i];
        end
      end
      if (BYPASS != 0) begin
        if (wr_ok[0] && (wr_addr[0] == rd_addr[p])) rd_val[p] = wr_data[0];
        if (wr_ok[1] && (wr_addr[1] == rd_addr[p])) rd_val[p] = wr_data[1];
      end
      if (!rd_in_range[p] || ((ZERO_REG != 0) && (rd_addr[p] == '0))) rd_val[p] = '0;
    end
  end

  if (READ_REG != 0) begin : g_read_reg
    logic [WIDTH-1:0] d_out_q [2];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        d_out_q[0] <= '0;
        d_out_q[1] <= '0;
      end else begin
        d_out_q[0] <= rd_val[0];
        d_out_q[1] <= rd_val[1];
      end
    end

    assign d_out_a = d_out_q[0];
    assign d_out_b = d_out_q[1];
  end else begin : g_read_comb
    assign d_out_a = rd_val[0];
    assign d_out_b = rd_val[1];
  end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r: four instances share stimulus so default, no-bypass,
// registered-read and zero-reg/short-depth variants are checked against hand-computed values.
module tb_reg_file_2w2r;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_0, wr_1;
  logic [2:0]  wr_addr_0, wr_addr_1;
  logic [15:0] d_in_0, d_in_1;
  logic [2:0]  rd_addr_a, rd_addr_b;

  logic [15:0] def_a, def_b, nby_a, nby_b, rr_a, rr_b, zr_a, zr_b;
  logic [15:0] zr_exp [6];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_2w2r u_def (
    .clk(clk), .reset(reset),
    .wr_0(wr_0), .wr_addr_0(wr_addr_0), .d_in_0(d_in_0),
    .wr_1(wr_1), .wr_addr_1(wr_addr_1), .d_in_1(d_in_1),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(def_a), .d_out_b(def_b)
  );

  reg_file_2w2r #(.BYPASS(0)) u_nby (
    .clk(clk), .reset(reset),
    .wr_0(wr_0), .wr_addr_0(wr_addr_0), .d_in_0(d_in_0),
    .wr_1(wr_1), .wr_addr_1(wr_addr_1), .d_in_1(d_in_1),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(nby_a), .d_out_b(nby_b)
  );

  reg_file_2w2r #(.READ_REG(1)) u_rr (
    .clk(clk), .reset(reset),
    .wr_0(wr_0), .wr_addr_0(wr_addr_0), .d_in_0(d_in_0),
    .wr_1(wr_1), .wr_addr_1(wr_addr_1), .d_in_1(d_in_1),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(rr_a), .d_out_b(rr_b)
  );

  reg_file_2w2r #(.DEPTH(6), .ZERO_REG(1)) u_zr (
    .clk(clk), .reset(reset),
    .wr_0(wr_0), .wr_addr_0(wr_addr_0), .d_in_0(d_in_0),
    .wr_1(wr_1), .wr_addr_1(wr_addr_1), .d_in_1(d_in_1),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(zr_a), .d_out_b(zr_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    wr_0      = 1'b0; wr_1      = 1'b0;
    wr_addr_0 = '0;   wr_addr_1 = '0;
    d_in_0    = '0;   d_in_1    = '0;
    rd_addr_a = '0;   rd_addr_b = '0;
    zr_exp    = '{16'h0000, 16'hba98, 16'h1234, 16'hcdef, 16'h0000, 16'h4567};

    #6;
    check("reset_def_a", def_a, 16'h0000);
    check("reset_rr_a",  rr_a,  16'h0000);
    check("reset_rr_b",  rr_b,  16'h0000);
    #6.5 reset = 1'b0;
    step();

    // Every address reads zero after reset.
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(a);
      #1;
      check("init_def_a", def_a, 16'h0000);
      check("init_def_b", def_b, 16'h0000);
      step();
      check("init_rr_a", rr_a, 16'h0000);
    end

    // Separate writes on each port.
    wr_0 = 1'b1; wr_addr_0 = 3'd3; d_in_0 = 16'hcdef;
    step();
    wr_0 = 1'b0;
    wr_1 = 1'b1; wr_addr_1 = 3'd7; d_in_1 = 16'h3210;
    step();
    wr_1 = 1'b0;
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    #1;
    check("wr_def_a", def_a, 16'hcdef);
    check("wr_def_b", def_b, 16'h3210);
    check("wr_nby_a", nby_a, 16'hcdef);
    check("wr_nby_b", nby_b, 16'h3210);
    check("wr_zr_a",  zr_a,  16'hcdef);
    check("wr_zr_oor_b", zr_b, 16'h0000);
    step();
    check("wr_rr_a", rr_a, 16'hcdef);
    check("wr_rr_b", rr_b, 16'h3210);

    // Same-address collision: port 1 wins.
    wr_0 = 1'b1; wr_addr_0 = 3'd5; d_in_0 = 16'h4567;
    wr_1 = 1'b1; wr_addr_1 = 3'd5; d_in_1 = 16'hba98;
    rd_addr_a = 3'd5;
    #1;
    check("coll_byp_def_a", def_a, 16'hba98);
    check("coll_old_nby_a", nby_a, 16'h0000);
    step();
    check("coll_rr_a", rr_a, 16'hba98);
    wr_0 = 1'b0; wr_1 = 1'b0;
    #1;
    check("coll_def_a", def_a, 16'hba98);
    check("coll_nby_a", nby_a, 16'hba98);

    // Different addresses: both land on the same edge.
    wr_0 = 1'b1; wr_addr_0 = 3'd5; d_in_0 = 16'h4567;
    wr_1 = 1'b1; wr_addr_1 = 3'd1; d_in_1 = 16'hba98;
    step();
    wr_0 = 1'b0; wr_1 = 1'b0;
    rd_addr_a = 3'd5; rd_addr_b = 3'd1;
    #1;
    check("dual_def_a", def_a, 16'h4567);
    check("dual_def_b", def_b, 16'hba98);
    check("dual_zr_a",  zr_a,  16'h4567);
    check("dual_zr_b",  zr_b,  16'hba98);
    step();
    check("dual_rr_a", rr_a, 16'h4567);
    check("dual_rr_b", rr_b, 16'hba98);

    // Bypass versus no bypass on a same-cycle read.
    wr_0 = 1'b1; wr_addr_0 = 3'd2; d_in_0 = 16'h1234;
    rd_addr_a = 3'd2;
    #1;
    check("byp_def_a", def_a, 16'h1234);
    check("nbyp_old_a", nby_a, 16'h0000);
    step();
    wr_0 = 1'b0;
    #1;
    check("nbyp_new_a", nby_a, 16'h1234);
    check("byp_rr_a",   rr_a,  16'h1234);

    // Register 0 hardwired to zero, including the bypass path.
    wr_0 = 1'b1; wr_addr_0 = 3'd0; d_in_0 = 16'hffff;
    rd_addr_a = 3'd0;
    #1;
    check("zero_byp_zr_a",  zr_a,  16'h0000);
    check("zero_byp_def_a", def_a, 16'hffff);
    step();
    wr_0 = 1'b0;
    #1;
    check("zero_zr_a",  zr_a,  16'h0000);
    check("zero_def_a", def_a, 16'hffff);

    // Out-of-range write on the six-entry instance.
    wr_0 = 1'b1; wr_addr_0 = 3'd6; d_in_0 = 16'haaaa;
    step();
    wr_0 = 1'b0;
    rd_addr_a = 3'd6;
    #1;
    check("oor_zr_a",  zr_a,  16'h0000);
    check("oor_def_a", def_a, 16'haaaa);
    for (int i = 0; i < 6; i++) begin
      rd_addr_b = 3'(i);
      #1;
      check("oor_zr_keep_b", zr_b, zr_exp[i]);
    end

    // Reset mid-run clears everything without a clock edge and blocks writes.
    rd_addr_a = 3'd3; rd_addr_b = 3'd5;
    step();
    check("pre_rst_rr_a",  rr_a,  16'hcdef);
    check("pre_rst_def_b", def_b, 16'h4567);
    #2 reset = 1'b1;
    #1;
    check("rst_def_a", def_a, 16'h0000);
    check("rst_def_b", def_b, 16'h0000);
    check("rst_nby_a", nby_a, 16'h0000);
    check("rst_nby_b", nby_b, 16'h0000);
    check("rst_rr_a",  rr_a,  16'h0000);
    check("rst_rr_b",  rr_b,  16'h0000);
    check("rst_zr_a",  zr_a,  16'h0000);
    check("rst_zr_b",  zr_b,  16'h0000);
    wr_0 = 1'b1; wr_addr_0 = 3'd3; d_in_0 = 16'h1111;
    #1;
    check("rst_wr_def_a", def_a, 16'h0000);
    step();
    reset = 1'b0;
    wr_0  = 1'b0;
    #1;
    check("post_rst_def_a", def_a, 16'h0000);
    check("post_rst_nby_a", nby_a, 16'h0000);
    step();
    check("post_rst_rr_a", rr_a, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
